// File: rtl/wideword_pkg.sv
// wideword_pkg: shared widths and fetch FSM states for the WideWord register-file port set.
package wideword_pkg;
    localparam int DW = 128;
    localparam int AW = 5;
    localparam int BW = DW / 8;
    typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;
endpackage

// File: rtl/rf_byte_merge.sv
// rf_byte_merge: replaces the enabled bytes of old_i with new_i when hit_i is set.
module rf_byte_merge
    import wideword_pkg::*;
(
    input  logic [DW-1:0] old_i,
    input  logic [DW-1:0] new_i,
    input  logic [BW-1:0] byteen_i,
    input  logic          hit_i,
    output logic [DW-1:0] out_o
);
    for (genvar b = 0; b < BW; b++) begin : g_byte
        assign out_o[8*b +: 8] = (hit_i && byteen_i[b]) ? new_i[8*b +: 8] : old_i[8*b +: 8];
    end
endmodule

// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch: issues dual regfile reads per request and returns both operands,
// merging same-cycle and in-flight writebacks so held operands never go stale.
module rf_operand_fetch
    import wideword_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_rs1,
    input  logic [AW-1:0] req_rs2,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [BW-1:0] wb_byteen,
    output logic [AW-1:0] rd1addr,
    output logic [AW-1:0] rd2addr,
    output logic          rd1en,
    output logic          rd2en,
    input  logic [DW-1:0] rd1data,
    input  logic [DW-1:0] rd2data,
    output logic [AW-1:0] wraddr,
    output logic [DW-1:0] wrdata,
    output logic [BW-1:0] wrbyteen,
    output logic          wren,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op1,
    output logic [DW-1:0] op2
);
    state_e        state_q, state_d;
    logic [AW-1:0] rs1_q, rs2_q;
    logic          fwd_en_q;
    logic [AW-1:0] fwd_addr_q;
    logic [DW-1:0] fwd_data_q;
    logic [BW-1:0] fwd_be_q;
    logic [DW-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [DW-1:0] f1, f2, w1, w2;
    logic          accept;

    assign wren     = wb_en;
    assign wraddr   = wb_addr;
    assign wrdata   = wb_data;
    assign wrbyteen = wb_byteen;

    assign req_ready = (state_q == IDLE) || (state_q == HOLD && op_ready);
    assign accept    = req_valid && req_ready;
    assign rd1en     = accept && !reset;
    assign rd2en     = rd1en;
    assign rd1addr   = rd1en ? req_rs1 : '0;
    assign rd2addr   = rd2en ? req_rs2 : '0;
    assign op_valid  = state_q == HOLD;
    assign op1       = op1_q;
    assign op2       = op2_q;

    // A write committed in the accept cycle is invisible to the read, so it is replayed here.
    rf_byte_merge u_fwd1 (.old_i(rd1data), .new_i(fwd_data_q), .byteen_i(fwd_be_q),
                          .hit_i(fwd_en_q && fwd_addr_q == rs1_q), .out_o(f1));
    rf_byte_merge u_fwd2 (.old_i(rd2data), .new_i(fwd_data_q), .byteen_i(fwd_be_q),
                          .hit_i(fwd_en_q && fwd_addr_q == rs2_q), .out_o(f2));
    rf_byte_merge u_wb1  (.old_i(state_q == READ ? f1 : op1_q), .new_i(wb_data), .byteen_i(wb_byteen),
                          .hit_i(wb_en && wb_addr == rs1_q), .out_o(w1));
    rf_byte_merge u_wb2  (.old_i(state_q == READ ? f2 : op2_q), .new_i(wb_data), .byteen_i(wb_byteen),
                          .hit_i(wb_en && wb_addr == rs2_q), .out_o(w2));

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        if (accept)
            state_d = READ;
        else if (state_q == READ)
            state_d = HOLD;
        else if (state_q == HOLD && op_ready)
            state_d = IDLE;
        if (state_q == READ || state_q == HOLD) begin
            op1_d = w1;
            op2_d = w2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            fwd_en_q   <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            if (accept) begin
                rs1_q      <= req_rs1;
                rs2_q      <= req_rs2;
                fwd_en_q   <= wb_en;
                fwd_addr_q <= wb_addr;
                fwd_data_q <= wb_data;
                fwd_be_q   <= wb_byteen;
            end
        end
    end
endmodule

// File: tb/tb_rf_operand_fetch.sv
// tb_rf_operand_fetch: directed vectors against a behavioural RegFileWW with hand-computed operands.
module tb_rf_operand_fetch;
    import wideword_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [AW-1:0] req_rs1 = '0, req_rs2 = '0;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic [BW-1:0] wb_byteen = '0;
    logic [AW-1:0] rd1addr, rd2addr, wraddr;
    logic          rd1en, rd2en, wren;
    logic [DW-1:0] rd1data = '0, rd2data = '0, wrdata;
    logic [BW-1:0] wrbyteen;
    logic          op_valid, op_ready = 1'b0;
    logic [DW-1:0] op1, op2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] exp_reg [8];

    localparam logic [DW-1:0] W0 = 128'h787897ea12fec60cae787897eac22354;
    localparam logic [DW-1:0] W7 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [DW-1:0] D3 = 128'h72345678_9abcdef0_99464645_66464666;
    localparam logic [DW-1:0] E3 = 128'h00000000_00000000_00464645_66464666;
    localparam logic [DW-1:0] E7 = 128'h0123456789abcdeffedcba987654bbcc;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    rf_operand_fetch dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_byteen(wb_byteen),
        .rd1addr(rd1addr), .rd2addr(rd2addr), .rd1en(rd1en), .rd2en(rd2en),
        .rd1data(rd1data), .rd2data(rd2data),
        .wraddr(wraddr), .wrdata(wrdata), .wrbyteen(wrbyteen), .wren(wren),
        .op_valid(op_valid), .op_ready(op_ready), .op1(op1), .op2(op2)
    );

    always #5 clk = ~clk;

    // Regfile: registered reads return pre-write contents; byte-enabled writes commit on the edge.
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (rd1en) rd1data <= mem[rd1addr];
        if (rd2en) rd2data <= mem[rd2addr];
        if (wren)
            for (int b = 0; b < BW; b++)
                if (wrbyteen[b]) mem[wraddr][8*b +: 8] <= wrdata[8*b +: 8];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be);
        wb_en = en;
        wb_addr = a;
        wb_data = d;
        wb_byteen = be;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_op_valid", 128'(op_valid), 128'd0);
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_rd1en", 128'(rd1en), 128'd0);
        check("rst_rd2en", 128'(rd2en), 128'd0);
        check("rst_op1", op1, '0);

        // plain read
        wb(1'b1, 5'd0, W0, 16'hffff);
        tick();
        wb(1'b1, 5'd7, W7, 16'hffff);
        tick();
        wb(1'b0, '0, '0, '0);
        req_valid = 1'b1;
        req_rs1 = 5'd0;
        req_rs2 = 5'd7;
        #1;
        check("rd_en", 128'(rd1en), 128'd1);
        check("rd2_addr", 128'(rd2addr), 128'd7);
        tick();
        req_valid = 1'b0;
        check("read_op_valid", 128'(op_valid), 128'd0);
        tick();
        check("plain_op_valid", 128'(op_valid), 128'd1);
        check("plain_op1", op1, W0);
        check("plain_op2", op2, W7);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("plain_done", 128'(op_valid), 128'd0);

        // same-cycle forward
        req_valid = 1'b1;
        req_rs1 = 5'd1;
        req_rs2 = 5'd3;
        wb(1'b1, 5'd1, D3, 16'h007f);
        tick();
        req_valid = 1'b0;
        wb(1'b0, '0, '0, '0);
        tick();
        check("fwd_op1", op1, E3);
        check("fwd_op2", op2, '0);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // in-flight forward overlapped by READ-cycle write, then backpressure
        req_valid = 1'b1;
        req_rs1 = 5'd7;
        req_rs2 = 5'd2;
        wb(1'b1, 5'd7, {112'h0, 16'hbbbb}, 16'h0003);
        tick();
        req_valid = 1'b0;
        wb(1'b1, 5'd7, {120'h0, 8'hcc}, 16'h0001);
        tick();
        wb(1'b0, '0, '0, '0);
        check("merge_op1", op1, E7);
        check("merge_op2", op2, '0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) wb(1'b1, 5'd2, ONES, 16'hffff);
            else if (k == 2) wb(1'b1, 5'd7, '0, 16'h0000);
            else wb(1'b0, '0, '0, '0);
            #1;
            check("bp_op_valid", 128'(op_valid), 128'd1);
            check("bp_req_ready", 128'(req_ready), 128'd0);
            tick();
        end
        wb(1'b0, '0, '0, '0);
        check("bp_op2", op2, ONES);
        check("bp_op1", op1, E7);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // back-to-back
        exp_reg[0] = W0;
        exp_reg[1] = E3;
        exp_reg[2] = ONES;
        exp_reg[3] = {16{8'h33}};
        exp_reg[4] = {16{8'h44}};
        exp_reg[5] = {16{8'h55}};
        exp_reg[6] = {16{8'h66}};
        exp_reg[7] = E7;
        for (int r = 3; r < 7; r++) begin
            wb(1'b1, 5'(r), exp_reg[r], 16'hffff);
            tick();
        end
        wb(1'b0, '0, '0, '0);
        op_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_rs1 = 5'(i);
            req_rs2 = 5'(7 - i);
            #1;
            check("b2b_req_ready", 128'(req_ready), 128'd1);
            tick();
            tick();
            check("b2b_op_valid", 128'(op_valid), 128'd1);
            check("b2b_op1", op1, exp_reg[i]);
            check("b2b_op2", op2, exp_reg[7 - i]);
        end
        req_valid = 1'b0;
        tick();
        op_ready = 1'b0;
        check("b2b_idle", 128'(op_valid), 128'd0);

        // reset while READ
        req_valid = 1'b1;
        req_rs1 = 5'd0;
        req_rs2 = 5'd1;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rr_op_valid", 128'(op_valid), 128'd0);
        check("rr_req_ready", 128'(req_ready), 128'd1);
        check("rr_op1", op1, '0);
        tick();
        check("rr_no_hold", 128'(op_valid), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
